cpu_mem_responder: RTL and testbench

//  Memory-side responder for the SimpleCPU RAM port (wrEn / addr_toRAM / data_toRAM / data_fromRAM).

---
 rtl/cpu_mem_responder.sv | 117 +++++++++++
 tb/tb_cpu_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for SimpleCPU: host program loader, 1-cycle registered reads, one MMIO output word.
// Optional macro WRITE_PROTECT_EN drops CPU writes below PROG_LIMIT and raises a sticky wp_fault.
//
// state | meaning
// LOAD  | CPU held in reset, loader streams the image from word 0
// RUN   | CPU released, loader ignored until the next rst
module cpu_mem_responder #(
    parameter int SIZE       = 10,
    parameter int DEPTH      = 1024,
    parameter int MMIO_ADDR  = 1023,
    parameter int PROG_LIMIT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    output logic            cpu_rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [31:0]     ld_data,
    input  logic            ld_last,
    output logic [31:0]     mmio_out,
    output logic            wp_fault
);

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]      state;
    logic [SIZE-1:0] ld_ptr;
    logic [31:0]     mem [DEPTH];

    logic            ld_fire;
    logic            is_mmio;
    logic            cpu_wr;
    logic            wp_hit;
    logic            mem_wr_cpu;
    logic            wr_en;
    logic [SIZE-1:0] wr_addr;
    logic [31:0]     wr_data;

    assign ld_ready = !rst && (state == LOAD);
    assign ld_fire  = ld_valid && ld_ready;
    assign cpu_rst  = (state != RUN);
    assign is_mmio  = (cpu_addr == SIZE'(MMIO_ADDR));
    assign cpu_wr   = !rst && (state == RUN) && cpu_wrEn;

`ifdef WRITE_PROTECT_EN
    assign wp_hit = (cpu_addr < SIZE'(PROG_LIMIT));
`else
    assign wp_hit = 1'b0;
`endif

    assign mem_wr_cpu = cpu_wr && !is_mmio && !wp_hit;

    // Loader and CPU writes never overlap (LOAD vs RUN), so one shared write port suffices.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cpu_addr;
        wr_data = cpu_wdata;
        if (ld_fire) begin
            wr_en   = 1'b1;
            wr_addr = ld_ptr;
            wr_data = ld_data;
        end else if (mem_wr_cpu) begin
            wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LOAD;
            ld_ptr <= '0;
        end else if (ld_fire) begin
            ld_ptr <= ld_ptr + 1'b1;
            if (ld_last || (ld_ptr == SIZE'(DEPTH - 1)))
                state <= RUN;
        end
    end

    // No reset on the array: the image must survive a CPU restart.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read happens before any same-edge write, so a colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (rst)
            cpu_rdata <= '0;
        else if (state == RUN)
            cpu_rdata <= is_mmio ? mmio_out : mem[cpu_addr];
        else
            cpu_rdata <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            mmio_out <= '0;
        else if (cpu_wr && is_mmio)
            mmio_out <= cpu_wdata;
    end

`ifdef WRITE_PROTECT_EN
    always_ff @(posedge clk) begin
        if (rst)
            wp_fault <= 1'b0;
        else if (cpu_wr && !is_mmio && wp_hit)
            wp_fault <= 1'b1;
    end
`else
    assign wp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: per-feature tasks checked against an array model of memory, MMIO and fault flag.
module tb_cpu_mem_responder;

    localparam int SIZE  = 10;
    localparam int DEPTH = 1024;
    localparam int MMIO  = 1023;
    localparam int PLIM  = 64;
`ifdef WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            cpu_wrEn;
    logic [SIZE-1:0] cpu_addr;
    logic [31:0]     cpu_wdata;
    logic [31:0]     cpu_rdata;
    logic            cpu_rst;
    logic            ld_valid;
    logic            ld_ready;
    logic [31:0]     ld_data;
    logic            ld_last;
    logic [31:0]     mmio_out;
    logic            wp_fault;

    cpu_mem_responder #(.SIZE(SIZE), .DEPTH(DEPTH), .MMIO_ADDR(MMIO), .PROG_LIMIT(PLIM)) dut (
        .clk(clk), .rst(rst), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rst(cpu_rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .mmio_out(mmio_out), .wp_fault(wp_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] mdl_mmio;
    bit          mdl_wpf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    endtask

    task automatic mdl_reset();
        mdl_mmio = '0;
        mdl_wpf  = 1'b0;
    endtask

    task automatic mdl_cpu_write(input int a, input logic [31:0] d);
        if (a == MMIO)              mdl_mmio = d;
        else if (WP && a < PLIM)    mdl_wpf  = 1'b1;
        else                        mdl[a]   = d;
    endtask

    task automatic cpu_rd(input int a, output logic [31:0] d);
        cpu_wrEn = 1'b0;
        cpu_addr = SIZE'(a);
        tick();
        d = cpu_rdata;
    endtask

    task automatic hold_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_reset();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        ld_valid = 1'b1; ld_data = 32'hFFFF_0000; ld_last = 1'b1;
        tick(); tick();
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
        total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
        total++; if (mmio_out !== 32'h0) begin bad++; $display("FAIL reset_mmio got=%h exp=0", mmio_out); end
        total++; if (wp_fault !== 1'b0) begin bad++; $display("FAIL reset_wp_fault got=%b exp=0", wp_fault); end
        idle();
        rst = 1'b0;
        mdl_reset();
        #1;
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL load_ld_ready got=%b exp=1", ld_ready); end
    endtask

    task automatic test_load_basic();
        logic [31:0] w [3];
        w[0] = 32'h20114045; w[1] = 32'h10114001; w[2] = 32'hb0118064;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = w[i]; ld_last = (i == 2);
            total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL load_cpu_rst_held word=%0d got=%b exp=1", i, cpu_rst); end
            tick();
            mdl[i] = w[i];
        end
        idle();
        total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL load_cpu_rst_release got=%b exp=0", cpu_rst); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL run_ld_ready got=%b exp=0", ld_ready); end
    endtask

    task automatic test_read();
        logic [31:0] d;
        for (int i = 2; i >= 0; i--) begin
            cpu_rd(i, d);
            total++; if (d !== mdl[i]) begin bad++; $display("FAIL read addr=%0d got=%h exp=%h", i, d, mdl[i]); end
        end
    endtask

    task automatic test_load_full();
        logic [31:0] d;
        hold_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0;
            if (i == DEPTH - 1) begin
                total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL full_cpu_rst_held got=%b exp=1", cpu_rst); end
            end
            tick();
            mdl[i] = ld_data;
        end
        ld_data = 32'hA5A5_A5A5;
        total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL full_cpu_rst_release got=%b exp=0", cpu_rst); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL full_ld_ready got=%b exp=0", ld_ready); end
        tick();
        idle();
        foreach (mdl[k]) if (k < 4 || k > DEPTH - 4) begin
            if (k == MMIO) continue;
            cpu_rd(k, d);
            total++; if (d !== mdl[k]) begin bad++; $display("FAIL full_read addr=%0d got=%h exp=%h", k, d, mdl[k]); end
        end
        cpu_rd(MMIO, d);
        total++; if (d !== mdl_mmio) begin bad++; $display("FAIL full_mmio_read got=%h exp=%h", d, mdl_mmio); end
    endtask

    task automatic test_same_addr();
        logic [31:0] old;
        logic [31:0] d;
        old = mdl[5];
        cpu_wrEn = 1'b1; cpu_addr = 10'd5; cpu_wdata = 32'hDEADBEEF;
        tick();
        mdl_cpu_write(5, 32'hDEADBEEF);
        total++; if (cpu_rdata !== old) begin bad++; $display("FAIL rbw_old got=%h exp=%h", cpu_rdata, old); end
        cpu_rd(5, d);
        total++; if (d !== mdl[5]) begin bad++; $display("FAIL rbw_new got=%h exp=%h", d, mdl[5]); end
        total++; if (wp_fault !== mdl_wpf) begin bad++; $display("FAIL rbw_wp_fault got=%b exp=%b", wp_fault, mdl_wpf); end
    endtask

    task automatic test_mmio();
        logic [31:0] old;
        logic [31:0] d;
        logic [31:0] mem_word;
        old = mdl_mmio;
        mem_word = mdl[MMIO];
        cpu_wrEn = 1'b1; cpu_addr = SIZE'(MMIO); cpu_wdata = 32'h1234;
        tick();
        mdl_cpu_write(MMIO, 32'h1234);
        total++; if (cpu_rdata !== old) begin bad++; $display("FAIL mmio_rbw got=%h exp=%h", cpu_rdata, old); end
        total++; if (mmio_out !== 32'h1234) begin bad++; $display("FAIL mmio_out got=%h exp=00001234", mmio_out); end
        cpu_rd(MMIO, d);
        total++; if (d !== 32'h1234) begin bad++; $display("FAIL mmio_read got=%h exp=00001234", d); end
        cpu_rd(MMIO - 1, d);
        total++; if (d !== mdl[MMIO - 1]) begin bad++; $display("FAIL mmio_neighbor got=%h exp=%h", d, mdl[MMIO - 1]); end
        if (mem_word !== mdl[MMIO]) begin
            total++; bad++; $display("FAIL mmio_model_backing got=%h exp=%h", mdl[MMIO], mem_word);
        end
    endtask

    task automatic test_random();
        int          a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          we;
        for (int n = 0; n < 400; n++) begin
            a  = ($urandom_range(0, 7) == 0) ? MMIO : int'($urandom_range(0, 127));
            if (a == 5) a = 6;
            d  = $urandom;
            we = 1'($urandom_range(0, 1));
            exp_rd = (a == MMIO) ? mdl_mmio : mdl[a];
            cpu_wrEn = we; cpu_addr = SIZE'(a); cpu_wdata = d;
            tick();
            if (we) mdl_cpu_write(a, d);
            total++; if (cpu_rdata !== exp_rd) begin bad++; $display("FAIL rand_rd n=%0d addr=%0d got=%h exp=%h", n, a, cpu_rdata, exp_rd); end
            total++; if (mmio_out !== mdl_mmio) begin bad++; $display("FAIL rand_mmio n=%0d got=%h exp=%h", n, mmio_out, mdl_mmio); end
            total++; if (wp_fault !== mdl_wpf) begin bad++; $display("FAIL rand_wpf n=%0d got=%b exp=%b", n, wp_fault, mdl_wpf); end
        end
        idle();
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        bit          vpat [5];
        int          ptr;
        idle();
        rst = 1'b1;
        tick();
        total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL midrst_cpu_rst got=%b exp=1", cpu_rst); end
        total++; if (mmio_out !== 32'h0) begin bad++; $display("FAIL midrst_mmio got=%h exp=0", mmio_out); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", cpu_rdata); end
        total++; if (wp_fault !== 1'b0) begin bad++; $display("FAIL midrst_wpf got=%b exp=0", wp_fault); end
        rst = 1'b0;
        mdl_reset();
        // Reload four words while the CPU port tries to write; those writes must be ignored.
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = $urandom; ld_last = (i == 3);
            cpu_wrEn = 1'b1; cpu_addr = (i % 2) ? SIZE'(MMIO) : 10'd5; cpu_wdata = 32'h0BAD_0BAD;
            tick();
            mdl[i] = ld_data;
            total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL load_rdata_zero i=%0d got=%h exp=0", i, cpu_rdata); end
        end
        idle();
        total++; if (mmio_out !== 32'h0) begin bad++; $display("FAIL load_mmio_ignored got=%h exp=0", mmio_out); end
        for (int i = 0; i < 4; i++) begin
            cpu_rd(i, d);
            total++; if (d !== mdl[i]) begin bad++; $display("FAIL reload_read addr=%0d got=%h exp=%h", i, d, mdl[i]); end
        end
        cpu_rd(5, d);
        total++; if (d !== mdl[5]) begin bad++; $display("FAIL reload_mem5 got=%h exp=%h", d, mdl[5]); end

        hold_reset();
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 1;
        ptr = 0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = vpat[i]; ld_data = $urandom; ld_last = (i == 4);
            tick();
            if (vpat[i]) begin mdl[ptr] = ld_data; ptr++; end
        end
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = 32'hCAFE_0000 + i; ld_last = 1'b1;
            total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL gaps_run_ld_ready got=%b exp=0", ld_ready); end
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            cpu_rd(i, d);
            total++; if (d !== mdl[i]) begin bad++; $display("FAIL gaps_read addr=%0d got=%h exp=%h", i, d, mdl[i]); end
        end
        cpu_rd(5, d);
        total++; if (d !== mdl[5]) begin bad++; $display("FAIL gaps_mem5 got=%h exp=%h", d, mdl[5]); end
    endtask

    task automatic test_write_protect();
        logic [31:0] d;
        cpu_wrEn = 1'b1; cpu_addr = 10'd10; cpu_wdata = 32'h55;
        tick();
        mdl_cpu_write(10, 32'h55);
        cpu_wrEn = 1'b0;
        total++; if (wp_fault !== mdl_wpf) begin bad++; $display("FAIL wp_flag got=%b exp=%b", wp_fault, mdl_wpf); end
        cpu_rd(10, d);
        total++; if (d !== mdl[10]) begin bad++; $display("FAIL wp_addr10 got=%h exp=%h", d, mdl[10]); end
        cpu_wrEn = 1'b1; cpu_addr = 10'd100; cpu_wdata = 32'h55;
        tick();
        mdl_cpu_write(100, 32'h55);
        cpu_rd(100, d);
        total++; if (d !== 32'h55) begin bad++; $display("FAIL wp_addr100 got=%h exp=00000055", d); end
        tick(); tick();
        total++; if (wp_fault !== mdl_wpf) begin bad++; $display("FAIL wp_sticky got=%b exp=%b", wp_fault, mdl_wpf); end
        hold_reset();
        total++; if (wp_fault !== 1'b0) begin bad++; $display("FAIL wp_cleared got=%b exp=0", wp_fault); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_basic();
        test_read();
        test_load_full();
        test_same_addr();
        test_mmio();
        test_random();
        test_reset_mid_run();
        test_write_protect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
